// File: rtl/bram_sdp.sv
// bram_sdp: simple dual-port block RAM, one write port with byte enables
// and one read port, sharing a single clock.
// After reset the whole array is cleared to zero, one word per cycle;
// init_done rises once the clear is finished, and user accesses are
// ignored until then.
// RDW_MODE selects the result of a same-address read and write in one
// cycle: 0 returns the old word, 1 returns the word after the byte merge.
// Optional build macro BRAM_SDP_OUT_REG_EN adds one register stage on
// rd_data/rd_valid, which makes the read latency 2.
module bram_sdp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int RDW_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                init_done
);

    localparam int          DEPTH = 2 ** ADDR_W;
    localparam int unsigned BE_W  = DATA_W / 8;

    typedef enum logic {
        INIT,
        IDLE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   init_cnt;

    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [BE_W-1:0]     mem_be;
    logic [DATA_W-1:0]   mem_wdata;
    logic                rd_accept;
    logic [DATA_W-1:0]   rd_word;

    logic                rd_valid_s1;
    logic [DATA_W-1:0]   rd_data_s1;

    // State register: reset always returns to the clear phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Clear address counter, runs only while clearing; restarts at 0 on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt <= '0;
        end else if (state == INIT) begin
            init_cnt <= init_cnt + ADDR_W'(1);
        end
    end

    // Next state and write-port mux: the clear owns the write port during INIT.
    always_comb begin
        state_nxt = state;
        init_done = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = wr_addr;
        mem_be    = '0;
        mem_wdata = wr_data;
        rd_accept = 1'b0;
        case (state)
            INIT: begin
                mem_we    = !rst;
                mem_addr  = init_cnt;
                mem_be    = '1;
                mem_wdata = '0;
                if (init_cnt == '1) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                init_done = 1'b1;
                mem_we    = wr_en && !rst;
                mem_be    = wr_be;
                rd_accept = rd_en && !rst;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    // Read word, with the same-cycle write bytes merged in when RDW_MODE=1.
    always_comb begin
        rd_word = mem[rd_addr];
        if (RDW_MODE == 1) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (mem_we && (mem_addr == rd_addr) && mem_be[i]) begin
                    rd_word[8*i +: 8] = mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Memory array write with per-byte enables; the array itself is not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // First read stage: capture the word on an accepted read, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_s1 <= 1'b0;
            rd_data_s1  <= '0;
        end else begin
            rd_valid_s1 <= rd_accept;
            if (rd_accept) begin
                rd_data_s1 <= rd_word;
            end
        end
    end

`ifdef BRAM_SDP_OUT_REG_EN
    logic                rd_valid_s2;
    logic [DATA_W-1:0]   rd_data_s2;

    // Optional output stage: data only moves when stage one carries a new word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_s2 <= 1'b0;
            rd_data_s2  <= '0;
        end else begin
            rd_valid_s2 <= rd_valid_s1;
            if (rd_valid_s1) begin
                rd_data_s2 <= rd_data_s1;
            end
        end
    end

    assign rd_valid = rd_valid_s2;
    assign rd_data  = rd_data_s2;
`else
    assign rd_valid = rd_valid_s1;
    assign rd_data  = rd_data_s1;
`endif

endmodule

// File: doc/bram_sdp.md
BRAM_SDP -- requirements
Module: bram_sdp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: word width in bits; a multiple of 8, at least 8.
REQ-002 The block SHALL have parameter ADDR_W, default 10: address width; DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have parameter RDW_MODE, default 0: same-address read-during-write policy; 0 = old data, 1 = new data.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port wr_en, input, 1 bit: write request.
REQ-007 The block SHALL have port wr_addr, input, ADDR_W bits: write address.
REQ-008 The block SHALL have port wr_be, input, DATA_W/8 bits: byte enables; bit i gates byte i (bits 8i+7 down to 8i).
REQ-009 The block SHALL have port wr_data, input, DATA_W bits: write data.
REQ-010 The block SHALL have port rd_en, input, 1 bit: read request.
REQ-011 The block SHALL have port rd_addr, input, ADDR_W bits: read address.
REQ-012 The block SHALL have port rd_data, output, DATA_W bits: registered read data.
REQ-013 The block SHALL have port rd_valid, output, 1 bit: one-cycle pulse marking rd_data as new.
REQ-014 The block SHALL have port init_done, output, 1 bit: high once the memory clear is complete.

Function
REQ-015 The block SHALL implement a two-state FSM, INIT and IDLE, with INIT entered on reset.
REQ-016 In INIT, the block SHALL write all-zero to mem[init_cnt] each cycle and increment init_cnt from 0.
REQ-017 After writing address DEPTH-1, the block SHALL move INIT->IDLE, so the clear takes exactly DEPTH cycles.
REQ-018 init_done SHALL be high for the whole of IDLE and low for the whole of INIT.
REQ-019 In INIT, wr_en and rd_en SHALL be ignored: no user write, rd_valid stays 0, rd_data holds.
REQ-020 In IDLE with wr_en=1, mem[wr_addr] byte i SHALL take wr_data byte i where wr_be[i]=1; other bytes are unchanged.
REQ-021 wr_en=1 with wr_be all-zero SHALL leave memory unchanged.
REQ-022 In IDLE with rd_en=1 in cycle N, rd_data SHALL present mem[rd_addr] and rd_valid SHALL be 1 in cycle N+1 (latency 1).
REQ-023 rd_valid SHALL be 0 in any cycle not following an accepted read.
REQ-024 rd_data SHALL hold its last value when no read completes.
REQ-025 Back-to-back reads SHALL be accepted every cycle at full throughput.
REQ-026 Same-cycle read and write to different addresses SHALL both complete without interaction.
REQ-027 Same-cycle read and write to the same address with RDW_MODE=0 SHALL return the pre-write word.
REQ-028 Same-cycle read and write to the same address with RDW_MODE=1 SHALL return the merged word: new bytes where wr_be=1, old bytes elsewhere.
REQ-029 Addresses SHALL be exactly ADDR_W bits, so no out-of-range access is possible and no wrap logic is needed.

Reset
REQ-030 With rst=1 at an edge, the block SHALL set state=INIT, init_cnt=0, init_done=0, rd_valid=0 and rd_data=0, including any pipeline register.
REQ-031 rst asserted mid-INIT or mid-read SHALL abort the operation; in-flight reads SHALL produce no rd_valid, and the clear SHALL restart at address 0.
REQ-032 rst SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-033 With macro BRAM_SDP_OUT_REG_EN defined, the block SHALL add one output register stage on rd_data and rd_valid, giving read latency 2 and an unchanged collision result.
REQ-034 With BRAM_SDP_OUT_REG_EN undefined, read latency SHALL be 1 with no extra register.

Verification
REQ-035 Reset, then hold 1023 cycles -> init_done=0; cycle 1024 after reset -> init_done=1; reading any address returns 0x00000000.
REQ-036 Write 0xDEADBEEF to addr 5 with be=1111, then be=0010 with 0x0000AA00; read 5 -> 0xDEADAAEF, rd_valid one cycle later (two with the macro).
REQ-037 With mem[7]=0x11111111, same-cycle write 0x22222222 be=1111 and read of 7 -> 0x11111111 (RDW_MODE=0) or 0x22222222 (RDW_MODE=1).
REQ-038 Reads of addrs 0..3 on consecutive cycles -> four consecutive rd_valid pulses, data in order.
REQ-039 rst pulsed at INIT cycle 500 -> init_done stays 0 until 1024 cycles after the new reset.
REQ-040 rd_en during INIT -> no rd_valid; wr_en during INIT -> address still reads 0 after init.
